// File: rtl/ibex_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ibex_bus_arbiter_if
// Brief    : Ibex instr/data req-gnt-rvalid ports plus the shared Avalon-MM
//            master port, bundled for the instr/data bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ibex_bus_arbiter_if;
    // Ibex instruction side
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    // Ibex data side
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    // Avalon-MM master side
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_address_o;
    logic [3:0]  avm_byteenable_o;
    logic [31:0] avm_writedata_o;
    logic        avm_waitrequest_i;
    logic        avm_readdatavalid_i;
    logic [31:0] avm_readdata_i;
    logic        avm_writeresponsevalid_i;
    logic [1:0]  avm_response_i;

    // The arbiter serves the core, so it takes the slave view of the bundle.
    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  avm_waitrequest_i, avm_readdatavalid_i, avm_readdata_i,
        input  avm_writeresponsevalid_i, avm_response_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o,
        output avm_writedata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output avm_waitrequest_i, avm_readdatavalid_i, avm_readdata_i,
        output avm_writeresponsevalid_i, avm_response_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o,
        input  avm_writedata_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_bus_arbiter
// Brief    : Shares one pipelined Avalon-MM master between the Ibex instr and
//            data interfaces; an order FIFO routes in-order responses back.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARB_MODE        = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ibex_bus_arbiter_if.slave bus,
    output logic              proto_err_o
);

    localparam int unsigned         c_PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned         c_CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);

    // Order FIFO: one {source, write} tag per accepted command.
    logic [MAX_OUTSTANDING-1:0] r_fifo_src;     // 1 = data port
    logic [MAX_OUTSTANDING-1:0] r_fifo_we;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;

    logic r_lock;
    logic r_lock_data;
    logic r_last_data;
    logic r_proto_err;

    logic        w_sel_data;
    logic        w_sel_req;
    logic        w_sel_we;
    logic        w_not_full;
    logic        w_cmd;
    logic        w_accept;
    logic        w_stall;
    logic        w_rsp;
    logic        w_empty;
    logic        w_pop;
    logic        w_head_data;
    logic        w_head_we;
    logic        w_both_strobes;
    logic        w_mismatch;
    logic        w_proto_set;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;

    // A stalled command owns the port until accepted, whatever the policy says.
    always_comb begin
        w_sel_data = 1'b0;
        if (r_lock) begin
            w_sel_data = r_lock_data;
        end else if (ARB_MODE == 1) begin
            w_sel_data = bus.data_req_i;
        end else if (bus.data_req_i && bus.instr_req_i) begin
            w_sel_data = ~r_last_data;
        end else begin
            w_sel_data = bus.data_req_i;
        end
    end

    assign w_sel_req  = w_sel_data ? bus.data_req_i : bus.instr_req_i;
    assign w_sel_we   = w_sel_data & bus.data_we_i;
    // Registered count only: a same-cycle pop must not open a slot.
    assign w_not_full = (r_count < c_CNT_MAX);
    assign w_cmd      = w_sel_req & w_not_full;
    assign w_accept   = w_cmd & ~bus.avm_waitrequest_i;
    assign w_stall    = w_cmd &  bus.avm_waitrequest_i;

    assign bus.avm_read_o       = w_cmd & ~w_sel_we;
    assign bus.avm_write_o      = w_cmd &  w_sel_we;
    assign bus.avm_address_o    = !w_cmd    ? 32'h0 :
                                  w_sel_data ? bus.data_addr_i : bus.instr_addr_i;
    assign bus.avm_byteenable_o = !w_cmd    ? 4'h0 :
                                  w_sel_data ? bus.data_be_i : 4'hF;
    assign bus.avm_writedata_o  = (w_cmd & w_sel_we) ? bus.data_wdata_i : 32'h0;

    assign bus.instr_gnt_o = w_accept & ~w_sel_data;
    assign bus.data_gnt_o  = w_accept &  w_sel_data;

    // Response routing: the FIFO head names the requester, zero latency.
    assign w_rsp       = bus.avm_readdatavalid_i | bus.avm_writeresponsevalid_i;
    assign w_empty     = (r_count == '0);
    assign w_pop       = w_rsp & ~w_empty;
    assign w_head_data = r_fifo_src[r_rd_ptr];
    assign w_head_we   = r_fifo_we[r_rd_ptr];
    assign w_rsp_data  = bus.avm_readdatavalid_i ? bus.avm_readdata_i : 32'h0;
    assign w_rsp_err   = (bus.avm_response_i != 2'b00);

    assign bus.instr_rvalid_o = w_pop & ~w_head_data;
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? w_rsp_data : 32'h0;
    assign bus.instr_err_o    = bus.instr_rvalid_o & w_rsp_err;
    assign bus.data_rvalid_o  = w_pop & w_head_data;
    assign bus.data_rdata_o   = bus.data_rvalid_o ? w_rsp_data : 32'h0;
    assign bus.data_err_o     = bus.data_rvalid_o & w_rsp_err;

    assign w_both_strobes = bus.avm_readdatavalid_i & bus.avm_writeresponsevalid_i;
    assign w_mismatch     = w_pop &
                            ((bus.avm_readdatavalid_i & ~bus.avm_writeresponsevalid_i &  w_head_we) |
                             (bus.avm_writeresponsevalid_i & ~bus.avm_readdatavalid_i & ~w_head_we));
    assign w_proto_set    = (w_rsp & w_empty) | w_both_strobes | w_mismatch;

    assign proto_err_o = r_proto_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_src  <= '0;
            r_fifo_we   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lock      <= 1'b0;
            r_lock_data <= 1'b0;
            r_last_data <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fifo_src[r_wr_ptr] <= w_sel_data;
                r_fifo_we[r_wr_ptr]  <= w_sel_we;
                r_wr_ptr             <= r_wr_ptr + c_PTR_ONE;
                r_last_data          <= w_sel_data;
                r_lock               <= 1'b0;
            end else if (w_stall) begin
                r_lock      <= 1'b1;
                r_lock_data <= w_sel_data;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
